// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state codes and op-class decode for the multiply issue controller.
// The MADD family only decodes as a multiply when MULDIV_MADD_EN is defined.
package muldiv_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_MTHI  = 4'd3,
    MD_MTLO  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8
  } muldiv_op_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_mul_op(muldiv_op_t op);
`ifdef MULDIV_MADD_EN
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
`else
    return op inside {MD_MULT, MD_MULTU};
`endif
  endfunction

  function automatic logic is_signed_op(muldiv_op_t op);
    return op inside {MD_MULT, MD_MADD, MD_MSUB};
  endfunction

  function automatic logic is_acc_op(muldiv_op_t op);
    return op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_sub_op(muldiv_op_t op);
    return op inside {MD_MSUB, MD_MSUBU};
  endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_hilo_regs.sv
// Architectural HI/LO storage; product and accumulate writes take precedence over MTHI/MTLO.
module hilo_regs #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mthi_we,
  input  logic                  mtlo_we,
  input  logic [DATA_W-1:0]     mt_dat,
  input  logic                  prod_we,
  input  logic                  acc_we,
  input  logic                  acc_sub,
  input  logic [2*DATA_W-1:0]   prod_dat,
  output logic [DATA_W-1:0]     hi_out,
  output logic [DATA_W-1:0]     lo_out
);

  logic [2*DATA_W-1:0] hilo_q, hilo_d, acc_sum;

  always_comb begin
    acc_sum = acc_sub ? (hilo_q - prod_dat) : (hilo_q + prod_dat);
    hilo_d  = hilo_q;
    if (prod_we) begin
      hilo_d = prod_dat;
    end else if (acc_we) begin
      hilo_d = acc_sum;
    end else begin
      if (mthi_we) hilo_d[2*DATA_W-1:DATA_W] = mt_dat;
      if (mtlo_we) hilo_d[DATA_W-1:0]        = mt_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hilo_q <= '0;
    else     hilo_q <= hilo_d;
  end

  assign hi_out = hilo_q[2*DATA_W-1:DATA_W];
  assign lo_out = hilo_q[DATA_W-1:0];

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage issue FSM for the multi-cycle multiplier: launch, hold operands until out_valid, write HI/LO.
// Optional MADD/MSUB accumulate path (extra ACC state) enabled by defining MULDIV_MADD_EN.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SKIP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [3:0]        ex_op,
  input  logic [DATA_W-1:0] ex_srca,
  input  logic [DATA_W-1:0] ex_srcb,
  input  logic              flush,
  output logic              stall_req,
  output logic              mul_in_valid,
  output logic              mul_sign,
  output logic [DATA_W-1:0] mul_srca,
  output logic [DATA_W-1:0] mul_srcb,
  input  logic              mul_out_valid,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic [DATA_W-1:0] mul_lo,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int CNT_W = (SKIP_CYCLES < 1) ? 1 : $clog2(SKIP_CYCLES + 1);

  muldiv_op_t          op;
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    skip_q, skip_d;
  logic [DATA_W-1:0]   srca_q, srca_d, srcb_q, srcb_d;
  logic                sign_q, sign_d;
  logic                md_ok, launch;
  logic                mthi_we, mtlo_we, prod_we, acc_we, acc_sub;
  logic [2*DATA_W-1:0] prod_dat;
`ifdef MULDIV_MADD_EN
  logic                acc_q, acc_d, sub_q, sub_d;
  logic [2*DATA_W-1:0] prod_q, prod_d;
`endif

  assign op     = muldiv_op_t'(ex_op);
  assign md_ok  = ex_valid && !flush;
  assign launch = (state_q == ST_IDLE) && md_ok && is_mul_op(op);

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    sign_d  = sign_q;
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    prod_we = 1'b0;
    acc_we  = 1'b0;
`ifdef MULDIV_MADD_EN
    acc_d  = acc_q;
    sub_d  = sub_q;
    prod_d = prod_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          srca_d  = ex_srca;
          srcb_d  = ex_srcb;
          sign_d  = is_signed_op(op);
          skip_d  = CNT_W'(SKIP_CYCLES);
          state_d = ST_BUSY;
`ifdef MULDIV_MADD_EN
          acc_d = is_acc_op(op);
          sub_d = is_sub_op(op);
`endif
        end else if (md_ok) begin
          mthi_we = (op == MD_MTHI);
          mtlo_we = (op == MD_MTLO);
        end
      end
      ST_BUSY: begin
        // A valid seen during the skip window belongs to the previous op.
        if (skip_q != '0) begin
          skip_d = skip_q - CNT_W'(1);
        end else if (mul_out_valid) begin
`ifdef MULDIV_MADD_EN
          if (acc_q) begin
            prod_d  = {mul_hi, mul_lo};
            state_d = ST_ACC;
          end else begin
            prod_we = 1'b1;
            state_d = ST_DONE;
          end
`else
          prod_we = 1'b1;
          state_d = ST_DONE;
`endif
        end
      end
`ifdef MULDIV_MADD_EN
      ST_ACC: begin
        acc_we  = 1'b1;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      mthi_we = 1'b0;
      mtlo_we = 1'b0;
      prod_we = 1'b0;
      acc_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
      sign_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
      prod_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      sign_q  <= sign_d;
`ifdef MULDIV_MADD_EN
      acc_q  <= acc_d;
      sub_q  <= sub_d;
      prod_q <= prod_d;
`endif
    end
  end

`ifdef MULDIV_MADD_EN
  assign acc_sub  = sub_q;
  assign prod_dat = (state_q == ST_ACC) ? prod_q : {mul_hi, mul_lo};
`else
  assign acc_sub  = 1'b0;
  assign prod_dat = {mul_hi, mul_lo};
`endif

  assign mul_in_valid = (state_q == ST_BUSY);
  assign stall_req    = launch || (state_q == ST_BUSY) || (state_q == ST_ACC);
  assign mul_sign     = sign_q;
  assign mul_srca     = srca_q;
  assign mul_srcb     = srcb_q;

  hilo_regs #(.DATA_W(DATA_W)) u_hilo (
    .clk      (clk),
    .rst      (rst),
    .mthi_we  (mthi_we),
    .mtlo_we  (mtlo_we),
    .mt_dat   (ex_srca),
    .prod_we  (prod_we),
    .acc_we   (acc_we),
    .acc_sub  (acc_sub),
    .prod_dat (prod_dat),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: behavioural multiplier with random latency and stale-valid pulses,
// plus a HI/LO reference model updated from the op semantics.
module tb_muldiv_issue_ctrl;
  import muldiv_pkg::*;

  logic        clk, rst, ex_valid, flush;
  logic [3:0]  ex_op;
  logic [31:0] ex_srca, ex_srcb;
  logic        stall_req, mul_in_valid, mul_sign, mul_out_valid;
  logic [31:0] mul_srca, mul_srcb, mul_hi, mul_lo, hi_out, lo_out;

  int ncmp = 0;
  int nfail = 0;
  int mcnt = 0;
  int lat = 1;
  bit stale = 0;
  logic [31:0] ref_hi = '0, ref_lo = '0;

  muldiv_issue_ctrl #(.DATA_W(32), .SKIP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_srca(ex_srca), .ex_srcb(ex_srcb), .flush(flush),
    .stall_req(stall_req), .mul_in_valid(mul_in_valid), .mul_sign(mul_sign),
    .mul_srca(mul_srca), .mul_srcb(mul_srcb), .mul_out_valid(mul_out_valid),
    .mul_hi(mul_hi), .mul_lo(mul_lo), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul64(logic [31:0] a, logic [31:0] b, bit s);
    if (s) return $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {32'b0, a} * {32'b0, b};
  endfunction

  // External multiplier: first in_valid cycle may carry a stale valid with junk data.
  always @(posedge clk) mcnt <= mul_in_valid ? mcnt + 1 : 0;
  assign mul_out_valid = mul_in_valid && ((mcnt >= lat) || (mcnt == 0 && stale));
  assign {mul_hi, mul_lo} = (mcnt == 0) ? 64'hDEAD_0BAD_5A5A_A5A5
                                        : mul64(mul_srca, mul_srcb, mul_sign);

  function automatic bit op_launches(logic [3:0] op);
`ifdef MULDIV_MADD_EN
    return op inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8};
`else
    return op inside {4'd1, 4'd2};
`endif
  endfunction

  function automatic bit op_signed(logic [3:0] op);
    return op inside {4'd1, 4'd5, 4'd7};
  endfunction

  function automatic bit op_acc(logic [3:0] op);
    return op inside {4'd5, 4'd6, 4'd7, 4'd8};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p, cur;
    p   = mul64(a, b, op_signed(op));
    cur = {ref_hi, ref_lo};
    if (!op_acc(op))               {ref_hi, ref_lo} = p;
    else if (op inside {4'd7, 4'd8}) {ref_hi, ref_lo} = cur - p;
    else                           {ref_hi, ref_lo} = cur + p;
  endtask

  task automatic run_mul(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit do_flush, input bit early);
    int nb, na;
    bit done;
    lat   = $urandom_range(1, 5);
    stale = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_srca = a; ex_srcb = b;
    #1 chk("launch_stall", stall_req, 1);
    nb = 0; na = 0; done = 0;
    while (!done && (nb + na) < 40) begin
      @(negedge clk);
      if (!stall_req) begin
        done = 1;
      end else if (mul_in_valid) begin
        nb++;
        chk("busy_srca", mul_srca, a);
        chk("busy_srcb", mul_srcb, b);
        chk("busy_sign", mul_sign, op_signed(op));
        if (do_flush && mul_out_valid && mcnt >= lat) flush = 1'b1;
      end else begin
        na++;
      end
    end
    chk("done_in_bound", done, 1);
    chk("busy_cycles", nb, lat + 1);
    chk("acc_cycles", na, (!do_flush && op_acc(op)) ? 1 : 0);
    chk("done_in_valid_low", mul_in_valid, 0);
    flush = 1'b0;
    if (!do_flush) model_mul(op, a, b);
    chk("hi_after", hi_out, ref_hi);
    chk("lo_after", lo_out, ref_lo);
    if (early) begin
      ex_valid = 1'b1; ex_op = MD_MULTU;
      #1 chk("done_no_launch", stall_req, 0);
    end else begin
      ex_valid = 1'b0;
    end
  endtask

  task automatic run_simple(input logic [3:0] op, input logic [31:0] a, input bit fl);
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_srca = a; flush = fl;
    #1 chk("simple_no_stall", stall_req, 0);
    @(negedge clk);
    ex_valid = 1'b0; flush = 1'b0;
    if (ex_valid === 1'b0 && !fl) begin
      if (op == 4'd3) ref_hi = a;
      if (op == 4'd4) ref_lo = a;
    end
    chk("simple_in_valid", mul_in_valid, 0);
    chk("simple_hi", hi_out, ref_hi);
    chk("simple_lo", lo_out, ref_lo);
  endtask

  initial begin
    logic [3:0] rop;
    rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_srca = '0; ex_srcb = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_in_valid", mul_in_valid, 0);
    chk("rst_sign", mul_sign, 0);
    chk("rst_srca", mul_srca, 0);
    chk("rst_srcb", mul_srcb, 0);
    chk("rst_stall", stall_req, 0);
    rst = 1'b0;

    run_mul(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    chk("multu_max_hi", hi_out, 32'hFFFF_FFFE);
    chk("multu_max_lo", lo_out, 32'h0000_0001);
    run_mul(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0);
    chk("mult_neg_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo_out, 32'hFFFF_FFFE);

    run_mul(MD_MULTU, 32'd3, 32'd5, 0, 1);
    chk("b2b_first_lo", lo_out, 32'd15);
    run_mul(MD_MULTU, 32'd7, 32'd9, 0, 0);
    chk("b2b_second_lo", lo_out, 32'd63);

    run_simple(MD_MTHI, 32'h1, 0);
    run_simple(MD_MTLO, 32'h2, 0);
    run_mul(MD_MULT, 32'd6, 32'd7, 1, 0);
    chk("flush_hi_kept", hi_out, 32'h1);
    chk("flush_lo_kept", lo_out, 32'h2);
    chk("flush_stall_low", stall_req, 0);

    run_simple(MD_MTHI, 32'hDEAD_BEEF, 0);
    run_simple(MD_MTLO, 32'h1234_5678, 0);
    chk("mthi_val", hi_out, 32'hDEAD_BEEF);
    chk("mtlo_val", lo_out, 32'h1234_5678);
    run_simple(MD_MTHI, 32'h0BAD_F00D, 1);
    chk("mthi_flushed", hi_out, 32'hDEAD_BEEF);

`ifdef MULDIV_MADD_EN
    run_simple(MD_MTHI, 32'h0, 0);
    run_simple(MD_MTLO, 32'h5, 0);
    run_mul(MD_MADDU, 32'd3, 32'd4, 0, 0);
    chk("maddu_hi", hi_out, 32'h0);
    chk("maddu_lo", lo_out, 32'h11);
    run_simple(MD_MTLO, 32'h5, 0);
    run_mul(MD_MSUB, 32'd1, 32'd6, 0, 0);
    chk("msub_hi", hi_out, 32'hFFFF_FFFF);
    chk("msub_lo", lo_out, 32'hFFFF_FFFF);
`endif

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(0, 8));
      if (op_launches(rop)) run_mul(rop, $urandom, $urandom, ($urandom_range(0, 4) == 0), 0);
      else                  run_simple(rop, $urandom, ($urandom_range(0, 5) == 0));
    end

    lat = 5; stale = 0;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = MD_MULT; ex_srca = 32'h1234; ex_srcb = 32'h5678;
    repeat (2) @(negedge clk);
    chk("midop_busy", mul_in_valid, 1);
    rst = 1'b1; ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; ref_hi = '0; ref_lo = '0;
    chk("midrst_hi", hi_out, 0);
    chk("midrst_lo", lo_out, 0);
    chk("midrst_in_valid", mul_in_valid, 0);
    chk("midrst_srca", mul_srca, 0);
    chk("midrst_stall", stall_req, 0);
    run_mul(MD_MULTU, 32'd11, 32'd13, 0, 0);
    chk("post_rst_lo", lo_out, 32'd143);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- EX-stage initiator for the multi-cycle multiplier handshake (in_valid/sign/srca/srcb in; out_valid/hi/lo out).
- Accepts MULT-class ops from the pipeline and launches them.
- Holds operands and in_valid stable until the multiplier reports out_valid, stalling the pipeline meanwhile.
- Owns the architectural HI/LO registers, written on completion or by MTHI/MTLO.

Parameters:
- DATA_W, 32: operand and HI/LO width.
- SKIP_CYCLES, 1: BUSY cycles at launch during which mul_out_valid is ignored (guards against stale valid).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_valid  in  1  EX-stage instruction valid
- ex_op  in  4  muldiv_op_t operation
- ex_srca  in  DATA_W  rs value
- ex_srcb  in  DATA_W  rt value
- flush  in  1  kill EX instruction / abort in-flight op
- stall_req  out  1  hold pipeline (combinational)
- mul_in_valid  out  1  to multiplier in_valid
- mul_sign  out  1  to multiplier sign
- mul_srca  out  DATA_W  to multiplier srca
- mul_srcb  out  DATA_W  to multiplier srcb
- mul_out_valid  in  1  from multiplier
- mul_hi  in  DATA_W  from multiplier
- mul_lo  in  DATA_W  from multiplier
- hi_out  out  DATA_W  architectural HI (registered)
- lo_out  out  DATA_W  architectural LO (registered)

Behaviour:
- Reset:
  - state=IDLE; hi_out=lo_out=0.
  - mul_in_valid=0, mul_sign=0, mul_srca=mul_srcb=0 (operand latches cleared); stall_req=0.
- Launch condition: ex_valid && !flush && ex_op∈{MULT,MULTU}.
- IDLE:
  - mul_in_valid=0.
  - On launch: latch operands and sign (MULT=1), load skip counter=SKIP_CYCLES, go BUSY. stall_req=1 combinationally this cycle.
  - MTHI/MTLO with ex_valid&&!flush: write hi_out/lo_out from ex_srca at the edge; no stall; state stays IDLE.
- BUSY:
  - mul_in_valid=1; mul_srca/srcb/sign driven from latches only, held stable every BUSY cycle.
  - stall_req=1. Skip counter decrements to 0.
  - When counter==0 && mul_out_valid: write {hi_out,lo_out}<={mul_hi,mul_lo}, go DONE.
  - No fixed latency assumed; the current multiplier asserts out_valid 4 cycles after the first BUSY cycle. Bench must tolerate any latency ≥ SKIP_CYCLES+1.
- DONE:
  - mul_in_valid=0, stall_req=0; pipeline advances at this edge; next state IDLE.
  - No launch accepted in DONE.
  - The mandatory in_valid-low cycle resets the multiplier's stability counter before the next op.
- Back-to-back MULTs: minimum spacing is DONE+IDLE, i.e. next BUSY begins 2 cycles after completion edge.
- flush:
  - From any state: next state IDLE, mul_in_valid=0 next cycle, no HI/LO write.
  - This holds even if mul_out_valid is high in the same cycle. flush has priority over completion and over MTHI/MTLO.
- rst mid-operation: same as reset; HI/LO cleared.
- Unsigned/signed: product is the full 2·DATA_W result; no truncation; sign only selects the multiplier flavour.
- MD_NONE or ex_valid=0 in IDLE: no action.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - ex_op MADD/MADDU/MSUB/MSUBU launch like MULT/MULTU (signed for MADD/MSUB).
  - On completion FSM enters ACC (stall_req=1, mul_in_valid=0): {hi,lo}<={hi,lo}±{mul_hi,mul_lo}, 64-bit wrap-around, then DONE.
  - Flush in ACC discards the result.
- Undefined: these encodings are treated as MD_NONE; no ACC state exists.

Decomposition:
- Package muldiv_pkg: muldiv_op_t enum (4-bit: NONE=0, MULT=1, MULTU=2, MTHI=3, MTLO=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8), FSM state enum (IDLE, BUSY, ACC, DONE), is_mul_op()/is_signed_op() functions.
- One natural sub-module: hilo_regs (HI/LO storage with write-enable mux for MTHI/MTLO/product/accumulate).

Test Plan:
- MULTU ex_srca=0xFFFFFFFF, ex_srcb=0xFFFFFFFF -> stall_req high until DONE; hi_out=0xFFFFFFFE, lo_out=0x00000001; mul_in_valid low in DONE.
- MULT ex_srca=0xFFFFFFFF, ex_srcb=0x00000002 -> mul_sign=1 throughout BUSY; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFFE.
- Back-to-back MULTU 3*5 then MULTU 7*9 -> lo_out=15 then 63; ≥1 cycle mul_in_valid=0 between ops; operands never change while mul_in_valid=1.
- MULT 6*7 with flush asserted in the cycle mul_out_valid rises, HI/LO preset 0x1/0x2 -> HI/LO remain 0x1/0x2; state IDLE; stall_req=0 next cycle.
- MTHI 0xDEADBEEF then MTLO 0x12345678 in IDLE -> no stall; hi_out/lo_out updated one edge after each.
- (MULDIV_MADD_EN) HI/LO=0/5, MADDU 3*4 -> lo_out=0x11, hi_out=0; MSUB 1*6 from HI/LO=0/5 -> HI/LO=0xFFFFFFFF/0xFFFFFFFF.
